// File: rtl/tlul_host_sched.sv
// Round-robin request scheduler for an N-host to one-device TL-UL socket.
// Tracks per-host outstanding credits, holds a stalled grant stable, and supports drain/quiesce.
module tlul_host_sched #(
    parameter int unsigned N      = 4,
    parameter int unsigned MaxOut = 2,
    localparam int unsigned IdxW  = $clog2(N),
    localparam int unsigned CntW  = $clog2(MaxOut + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_valid_i,
    output logic [N-1:0]      req_ready_o,
    output logic              dev_valid_o,
    input  logic              dev_ready_i,
    output logic [IdxW-1:0]   gnt_idx_o,
    input  logic              rsp_valid_i,
    input  logic              rsp_ready_i,
    input  logic [IdxW-1:0]   rsp_idx_i,
    input  logic              drain_i,
    output logic              drained_o,
    output logic [N*CntW-1:0] outstanding_o,
    output logic              err_o
);

    logic [CntW-1:0] cnt_q [N];
    logic [CntW-1:0] cnt_d [N];
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic [IdxW-1:0] last_gnt_q, last_gnt_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;

    logic [N-1:0]    elig;
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] cand;
    logic            found;
    logic            accept;
    logic            rsp_fire;
    logic            rsp_ok;
    logic            all_zero;

    // Grant path: locked grant wins, otherwise first eligible host from rr_ptr upward.
    always_comb begin
        elig  = '0;
        pick  = rr_ptr_q;
        cand  = rr_ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            elig[i] = req_valid_i[i] && (cnt_q[i] < CntW'(MaxOut)) && !drain_i;
        end
        for (int unsigned off = 0; off < N; off++) begin
            cand = IdxW'((32'(rr_ptr_q) + off) % N);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        if (lock_q) begin
            dev_valid_o = 1'b1;
            gnt_idx_o   = lock_idx_q;
        end else begin
            dev_valid_o = found;
            gnt_idx_o   = found ? pick : last_gnt_q;
        end
        accept      = dev_valid_o & dev_ready_i;
        req_ready_o = accept ? (N'(1) << gnt_idx_o) : '0;
    end

    // Credit bookkeeping; a completion is only valid against a non-zero counter.
    always_comb begin
        rsp_fire = rsp_valid_i & rsp_ready_i;
        rsp_ok   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            logic inc;
            logic dec;
            inc = accept && (gnt_idx_o == IdxW'(i));
            dec = rsp_fire && (rsp_idx_i == IdxW'(i)) && (cnt_q[i] != '0);
            if (dec) rsp_ok = 1'b1;
            cnt_d[i] = cnt_q[i];
            if (inc && !dec)      cnt_d[i] = cnt_q[i] + CntW'(1);
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CntW'(1);
        end
        err_d      = err_q | (rsp_fire & ~rsp_ok);
        rr_ptr_d   = accept ? IdxW'((32'(gnt_idx_o) + 32'd1) % N) : rr_ptr_q;
        lock_d     = dev_valid_o & ~dev_ready_i;
        lock_idx_d = lock_d ? gnt_idx_o : lock_idx_q;
        last_gnt_d = gnt_idx_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            last_gnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            outstanding_o[i*CntW +: CntW] = cnt_q[i];
            if (cnt_q[i] != '0) all_zero = 1'b0;
        end
    end

    assign drained_o = drain_i & all_zero & ~lock_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_tlul_host_sched.sv
// Directed and randomized checks of tlul_host_sched against a cycle-level credit/arbitration model.
module tb_tlul_host_sched;
    localparam int N      = 4;
    localparam int MAXOUT = 2;
    localparam int IW     = 2;
    localparam int CW     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic          dev_valid;
    logic          dev_ready;
    logic [IW-1:0] gnt_idx;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [IW-1:0] rsp_idx;
    logic          drain;
    logic          drained;
    logic [N*CW-1:0] outstanding;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt [N];
    int m_ptr, m_lock, m_lock_idx, m_err, m_last;
    int e_dv, e_gnt, e_rr, e_drained;

    // Observations captured at the sample point of the last step
    logic          o_dv, o_drained, o_err;
    logic [IW-1:0] o_gnt;
    logic [N-1:0]  o_rr;
    logic [N*CW-1:0] o_out;

    tlul_host_sched #(.N(N), .MaxOut(MAXOUT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .dev_valid_o  (dev_valid),
        .dev_ready_i  (dev_ready),
        .gnt_idx_o    (gnt_idx),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_idx_i    (rsp_idx),
        .drain_i      (drain),
        .drained_o    (drained),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_ptr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0; m_last = 0;
    endtask

    task automatic model_comb();
        int sum;
        if (m_lock != 0) begin
            e_dv  = 1;
            e_gnt = m_lock_idx;
        end else begin
            e_dv  = 0;
            e_gnt = m_last;
            for (int k = 0; k < N; k++) begin
                int h;
                h = (m_ptr + k) % N;
                if (e_dv == 0 && req_valid[h] && m_cnt[h] < MAXOUT && !drain) begin
                    e_dv  = 1;
                    e_gnt = h;
                end
            end
        end
        e_rr = (e_dv != 0 && dev_ready) ? (1 << e_gnt) : 0;
        sum = 0;
        for (int i = 0; i < N; i++) sum += m_cnt[i];
        e_drained = (drain && sum == 0 && m_lock == 0) ? 1 : 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (int'(rsp_idx) < N && m_cnt[rsp_idx] > 0) m_cnt[rsp_idx]--;
                else m_err = 1;
            end
            if (e_dv != 0 && dev_ready) begin
                m_cnt[e_gnt]++;
                m_ptr = (e_gnt + 1) % N;
            end
            m_lock = (e_dv != 0 && !dev_ready) ? 1 : 0;
            if (m_lock != 0) m_lock_idx = e_gnt;
            m_last = e_gnt;
        end
    endtask

    function automatic logic [N*CW-1:0] model_out();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    // One cycle: sample and check against the model, then advance the model at the edge.
    task automatic step();
        #1;
        model_comb();
        o_dv = dev_valid; o_gnt = gnt_idx; o_rr = req_ready;
        o_drained = drained; o_out = outstanding; o_err = err;
        chk("dev_valid",   32'(o_dv),      32'(e_dv));
        chk("gnt_idx",     32'(o_gnt),     32'(e_gnt));
        chk("req_ready",   32'(o_rr),      32'(e_rr));
        chk("drained",     32'(o_drained), 32'(e_drained));
        chk("outstanding", 32'(o_out),     32'(model_out()));
        chk("err",         32'(o_err),     32'(m_err));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic quiet();
        req_valid = '0; dev_ready = 1'b1; rsp_valid = 1'b0; rsp_ready = 1'b0;
        rsp_idx = '0; drain = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        quiet();
        do_reset();

        // Reset state
        step();
        chk("rst_dv", 32'(o_dv), 0);
        chk("rst_gnt", 32'(o_gnt), 0);
        chk("rst_out", 32'(o_out), 0);
        drain = 1'b1;
        step();
        chk("rst_drained", 32'(o_drained), 1);
        drain = 1'b0;

        // All hosts request continuously: round-robin until every host is full
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_gnt", 32'(o_gnt), 32'(i % 4));
            chk("rr_dv", 32'(o_dv), 1);
        end
        step();
        chk("full_dv", 32'(o_dv), 0);
        chk("full_out", 32'(o_out), 32'h0000_00AA);

        // Stall: grant to host 2 held while device not ready
        quiet(); do_reset();
        req_valid = 4'b0100; dev_ready = 1'b0;
        step();
        chk("stall_gnt1", 32'(o_gnt), 2);
        req_valid = 4'b0101;
        step();
        chk("stall_gnt2", 32'(o_gnt), 2);
        chk("stall_dv2", 32'(o_dv), 1);
        step();
        chk("stall_gnt3", 32'(o_gnt), 2);
        chk("stall_rr3", 32'(o_rr), 0);
        dev_ready = 1'b1;
        step();
        chk("stall_acc", 32'(o_rr), 32'h4);
        req_valid = 4'b0001;
        step();
        chk("stall_next", 32'(o_gnt), 0);
        chk("stall_next_rr", 32'(o_rr), 32'h1);

        // Host 1 full: completion and request in the same cycle
        quiet(); do_reset();
        req_valid = 4'b0010;
        step(); step();
        rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_idx = 2'd1;
        step();
        chk("h1_nogrant", 32'(o_dv), 0);
        chk("h1_out_full", 32'(o_out), 32'h08);
        rsp_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk("h1_freed", 32'(o_out), 32'h04);
        chk("h1_gnt", 32'(o_gnt), 1);
        chk("h1_rr", 32'(o_rr), 32'h2);
        req_valid = '0;
        step();
        chk("h1_refull", 32'(o_out), 32'h08);

        // Host 3 at count 1: simultaneous acceptance and completion
        quiet(); do_reset();
        req_valid = 4'b1000;
        step();
        rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_idx = 2'd3;
        step();
        chk("h3_acc", 32'(o_rr), 32'h8);
        rsp_valid = 1'b0; rsp_ready = 1'b0; req_valid = '0;
        step();
        chk("h3_cnt", 32'(o_out), 32'h40);
        chk("h3_err", 32'(o_err), 0);

        // Response to a host with no outstanding request
        rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_idx = 2'd2;
        step();
        chk("err_pre", 32'(o_err), 0);
        rsp_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk("err_set", 32'(o_err), 1);
        chk("err_cnt", 32'(o_out), 32'h40);
        step(); step();
        chk("err_sticky", 32'(o_err), 1);
        do_reset();
        step();
        chk("err_clr", 32'(o_err), 0);

        // Drain with host 0 outstanding
        quiet(); do_reset();
        req_valid = 4'b0001;
        step();
        drain = 1'b1;
        step();
        chk("drn_dv", 32'(o_dv), 0);
        chk("drn_busy", 32'(o_drained), 0);
        step();
        rsp_valid = 1'b1; rsp_ready = 1'b1; rsp_idx = 2'd0;
        step();
        chk("drn_busy2", 32'(o_drained), 0);
        rsp_valid = 1'b0; rsp_ready = 1'b0;
        step();
        chk("drn_done", 32'(o_drained), 1);
        chk("drn_dv2", 32'(o_dv), 0);

        // Randomized traffic against the model
        quiet(); do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = N'($urandom);
            dev_ready = ($urandom_range(0, 3) != 0);
            rsp_valid = ($urandom_range(0, 1) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rsp_idx   = IW'($urandom_range(0, N - 1));
            drain     = ($urandom_range(0, 9) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
